// File: rtl/frequency_generator_if.sv
// Bus between a frequency_generator and whatever drives it: digit/period requests in,
// generated waveform and status out.
interface frequency_generator_if #(
  parameter int BITS = 12
);
  logic [3:0]      ten_count;
  logic [3:0]      unit_count;
  logic            load;
  logic [BITS-1:0] period;
  logic            period_load;
  logic            signal;
  logic            window;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output ten_count, unit_count, load, period, period_load,
    input  signal, window, busy, dbg_state
  );

  modport slave (
    input  ten_count, unit_count, load, period, period_load,
    output signal, window, busy, dbg_state
  );
endinterface

// File: rtl/frequency_generator.sv
// Square-wave test source: exactly N = 0..99 rising edges per update window, spread evenly
// by a phase accumulator. Digits are converted BCD->binary and armed at a window boundary.
module frequency_generator #(
  parameter int              BITS          = 12,
  parameter logic [BITS-1:0] UPDATE_PERIOD = BITS'(1199)
) (
  input logic                  clk,
  input logic                  reset,
  frequency_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    ARMED   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      bin_q, bin_d;
  logic [3:0]      tens_q, tens_d;
  logic [6:0]      target_q, target_d;

  logic [BITS-1:0] period_q;
  logic [BITS-1:0] cnt_q;
  logic [BITS:0]   acc_q;
  logic            signal_q;

  logic [BITS:0]   p_len;
  logic [BITS:0]   half;
  logic [6:0]      eff;
  logic [7:0]      step;
  logic [BITS:0]   sum;
  logic            win_end;
  logic [3:0]      ten_c;
  logic [3:0]      unit_c;

  // Asking for more edges than P/2 would need more than one toggle per clock.
  assign p_len   = (BITS+1)'(period_q) + (BITS+1)'(1);
  assign half    = p_len >> 1;
  assign eff     = ((BITS+1)'(target_q) < half) ? target_q : half[6:0];
  assign step    = {eff, 1'b0};
  assign sum     = acc_q + (BITS+1)'(step);
  assign win_end = (cnt_q >= period_q);

  assign ten_c  = (bus.ten_count  > 4'd9) ? 4'd9 : bus.ten_count;
  assign unit_c = (bus.unit_count > 4'd9) ? 4'd9 : bus.unit_count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= UPDATE_PERIOD;
      cnt_q    <= '0;
      acc_q    <= '0;
      signal_q <= 1'b0;
    end else if (bus.period_load) begin
      period_q <= bus.period;
      cnt_q    <= '0;
      acc_q    <= '0;
      signal_q <= 1'b0;
    end else begin
      cnt_q <= win_end ? '0 : cnt_q + BITS'(1);
      // Over a whole window step*P is added and P removed per toggle, so acc returns to 0.
      if (sum >= p_len) begin
        acc_q    <= sum - p_len;
        signal_q <= ~signal_q;
      end else begin
        acc_q <= sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      tens_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      tens_q   <= tens_d;
      target_q <= target_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    tens_d   = tens_q;
    target_d = target_q;
    if (bus.load) begin
      bin_d   = {3'b000, unit_c};
      tens_d  = ten_c;
      state_d = CONVERT;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        CONVERT: begin
          if (tens_q != 4'd0) begin
            bin_d  = bin_q + 7'd10;
            tens_d = tens_q - 4'd1;
          end else begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          // Arming only at the boundary keeps each window at a single edge count.
          if (win_end) begin
            target_d = bin_q;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.signal    = signal_q;
  assign bus.window    = win_end;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed and randomized checks of frequency_generator against a per-window edge-count model.
module tb_frequency_generator;
  localparam int BITS = 12;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  frequency_generator_if #(.BITS(BITS)) bus ();

  frequency_generator #(
    .BITS         (BITS),
    .UPDATE_PERIOD(12'd1199)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int   edges;
    int   cycles;
    logic end_sig;
    int   min_run;
    int   max_run;
  } win_rec_t;

  win_rec_t recs[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Monitor state: one record per completed window (sampled mid-cycle, after the posedge).
  logic m_prev_sig;
  logic m_prev_win;
  int   m_edges;
  int   m_cycles;
  int   m_run_len;
  bit   m_run_ok;
  int   m_min;
  int   m_max;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset === 1'b1) begin
        m_prev_sig = 1'b0;
        m_prev_win = 1'b0;
        m_edges    = 0;
        m_cycles   = 0;
        m_run_len  = 0;
        m_run_ok   = 1'b0;
        m_min      = 1 << 30;
        m_max      = 0;
      end else begin
        m_cycles++;
        if (m_prev_sig === 1'b0 && bus.signal === 1'b1) m_edges++;
        if (bus.signal !== m_prev_sig) begin
          if (m_run_ok) begin
            if (m_run_len < m_min) m_min = m_run_len;
            if (m_run_len > m_max) m_max = m_run_len;
          end
          m_run_ok  = 1'b1;
          m_run_len = 1;
        end else begin
          m_run_len++;
        end
        if (m_prev_win === 1'b1) begin
          recs.push_back('{m_edges, m_cycles, bus.signal, m_min, m_max});
          m_edges  = 0;
          m_cycles = 0;
          m_min    = 1 << 30;
          m_max    = 0;
        end
        m_prev_sig = bus.signal;
        m_prev_win = bus.window;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: edges per window = min(clamped BCD value, (period+1)/2).
  function automatic int exp_edges(input int ten, input int unit, input int per);
    int t;
    int half;
    t    = ((ten > 9) ? 9 : ten) * 10 + ((unit > 9) ? 9 : unit);
    half = (per + 1) / 2;
    return (t < half) ? t : half;
  endfunction

  task automatic do_load(input int ten, input int unit);
    bus.ten_count  = 4'(ten);
    bus.unit_count = 4'(unit);
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic do_period(input int per);
    bus.period      = BITS'(per);
    bus.period_load = 1'b1;
    @(negedge clk);
    bus.period_load = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy !== 1'b0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", bus.busy, 0);
  endtask

  task automatic next_record(output win_rec_t r);
    int k = 0;
    while (recs.size() == 0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("window_seen", (recs.size() > 0), 1);
    if (recs.size() > 0) r = recs.pop_front();
    else r = '{-1, -1, 1'bx, 0, 0};
  endtask

  task automatic check_window(input string tag, input win_rec_t r, input int exp_e, input int per);
    check({tag, "_edges"}, r.edges, exp_e);
    check({tag, "_len"}, r.cycles, per + 1);
    check({tag, "_end_low"}, r.end_sig, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_rec_t r;
    int       k;
    int       per;
    int       ten;
    int       unit;

    reset           = 1'b1;
    bus.load        = 1'b0;
    bus.period_load = 1'b0;
    bus.ten_count   = '0;
    bus.unit_count  = '0;
    bus.period      = '0;
    repeat (3) @(negedge clk);

    check("rst_signal", bus.signal, 0);
    check("rst_window", bus.window, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", bus.dbg_state, 0);
    reset = 1'b0;

    // 1: 12 edges, two CONVERT clocks then ARMED until window end
    do_load(1, 2);
    check("t1_convert0", bus.dbg_state, 1);
    check("t1_busy", bus.busy, 1);
    @(negedge clk);
    check("t1_convert1", bus.dbg_state, 1);
    @(negedge clk);
    check("t1_armed", bus.dbg_state, 2);
    wait_idle();
    recs.delete();
    next_record(r);
    check_window("t1_w1", r, exp_edges(1, 2, 1199), 1199);
    next_record(r);
    check_window("t1_w2", r, exp_edges(1, 2, 1199), 1199);

    // 2: load 0/0 mid-window; current window keeps 12 edges, later windows are flat
    repeat (100) @(negedge clk);
    do_load(0, 0);
    wait_idle();
    next_record(r);
    check_window("t2_old", r, 12, 1199);
    next_record(r);
    check_window("t2_new", r, 0, 1199);

    // 3: 99 edges, phases of 6 or 7 clocks
    do_load(9, 9);
    wait_idle();
    recs.delete();
    next_record(r);
    check_window("t3_w1", r, 99, 1199);
    next_record(r);
    check_window("t3_w2", r, 99, 1199);
    check("t3_min_phase", r.min_run, 6);
    check("t3_max_phase", r.max_run, 7);

    // 4: short period clamps to P/2, toggles every clock
    do_period(99);
    do_load(9, 9);
    wait_idle();
    recs.delete();
    next_record(r);
    check_window("t4_w1", r, exp_edges(9, 9, 99), 99);
    next_record(r);
    check_window("t4_w2", r, 50, 99);
    check("t4_min_phase", r.min_run, 1);
    check("t4_max_phase", r.max_run, 1);

    // 5: out-of-range digits clamp to 9/9, conversion takes ten+1 clocks
    do_period(1199);
    do_load(15, 12);
    k = 0;
    while (bus.dbg_state === 2'd1 && k < 50) begin
      k++;
      @(negedge clk);
    end
    check("t5_convert_len", k, 10);
    wait_idle();
    recs.delete();
    next_record(r);
    check_window("t5", r, exp_edges(15, 12, 1199), 1199);

    // 6: reset mid-CONVERT aborts everything
    do_load(9, 9);
    repeat (3) @(negedge clk);
    check("t6_pre_state", bus.dbg_state, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_state", bus.dbg_state, 0);
    check("t6_signal", bus.signal, 0);
    check("t6_busy", bus.busy, 0);
    reset = 1'b0;
    recs.delete();
    next_record(r);
    check("t6_target0_edges", r.edges, 0);

    // 6b: a load while ARMED restarts conversion; only the last digits apply
    do_load(3, 4);
    k = 0;
    while (bus.dbg_state !== 2'd2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_armed", bus.dbg_state, 2);
    do_load(5, 6);
    check("t6_restart", bus.dbg_state, 1);
    wait_idle();
    while (recs.size() > 0) begin
      r = recs.pop_front();
      check("t6_no_old_digits", r.edges, 0);
    end
    next_record(r);
    check_window("t6_last", r, exp_edges(5, 6, 1199), 1199);

    // Randomized period and digits against the model
    for (int i = 0; i < 5; i++) begin
      per  = int'($urandom_range(20, 700));
      ten  = int'($urandom_range(0, 15));
      unit = int'($urandom_range(0, 15));
      do_period(per);
      do_load(ten, unit);
      wait_idle();
      recs.delete();
      next_record(r);
      check_window($sformatf("rnd%0d", i), r, exp_edges(ten, unit, per), per);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
